// File: rtl/fractal_sync_rf_arbiter.sv
// Round-robin arbiter sharing N_PORTS fractal-sync RF ports among N_REQ check/set requesters.
// Grants are combinational (zero-latency accept); each response is registered one cycle after its grant.
package fractal_sync_pkg;
    localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_rf_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned N_REGS    = 2,
    parameter int unsigned IDX_WIDTH = 1,
    localparam int unsigned SD_WIDTH = fractal_sync_pkg::SD_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_REQ-1:0]                     req_valid_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    input  logic [N_REQ-1:0]                     req_check_i,
    input  logic [N_REQ-1:0][IDX_WIDTH-1:0]      req_idx_i,
    input  logic [N_REQ-1:0][SD_WIDTH-1:0]       req_sd_i,
    output logic [N_REQ-1:0]                     rsp_valid_o,
    input  logic [N_REQ-1:0]                     rsp_ready_i,
    output logic [N_REQ-1:0]                     rsp_sync_o,
    output logic [N_REQ-1:0][SD_WIDTH-1:0]       rsp_sd_o,
    output logic [N_PORTS-1:0]                   rf_check_o,
    output logic [N_PORTS-1:0]                   rf_set_o,
    output logic [N_PORTS-1:0][IDX_WIDTH-1:0]    rf_idx_o,
    output logic [N_PORTS-1:0]                   rf_idx_valid_o,
    output logic [N_PORTS-1:0][SD_WIDTH-1:0]     rf_sd_o,
    input  logic [N_PORTS-1:0]                   rf_present_i,
    input  logic [N_PORTS-1:0][SD_WIDTH-1:0]     rf_sd_i
);

    localparam int unsigned RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    if ((64'd1 << IDX_WIDTH) < 64'(N_REGS)) begin : g_idx_width_chk
        $error("IDX_WIDTH too small to address N_REGS registers");
    end
    if (N_PORTS < 1 || N_PORTS > N_REQ) begin : g_ports_chk
        $error("N_PORTS must be in 1..N_REQ");
    end
    if (N_REQ < 1) begin : g_req_chk
        $error("N_REQ must be at least 1");
    end

    logic [RR_W-1:0]                  rr_q;
    logic [RR_W-1:0]                  rr_nxt;
    logic [N_REQ-1:0]                 rsp_valid_q;
    logic [N_REQ-1:0]                 rsp_sync_q;
    logic [N_REQ-1:0][SD_WIDTH-1:0]   rsp_sd_q;

    logic [N_REQ-1:0]                 eligible;
    logic [N_REQ-1:0]                 granted;
    logic [N_REQ-1:0][PORT_W-1:0]     port_of;
    logic [N_REQ-1:0]                 rsp_hit;
    logic [N_PORTS-1:0]               port_used;
    logic [N_PORTS-1:0][RR_W-1:0]     port_req;
    logic [N_PORTS-1:0][IDX_WIDTH-1:0] port_idx;
    logic                             any_grant;
    logic [RR_W-1:0]                  last_grant;
    logic                             collide;
    int unsigned                      n_grant;
    int unsigned                      scan_r;

    always_comb begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
            eligible[r] = req_valid_i[r] && !rsp_valid_q[r] && (32'(req_idx_i[r]) < N_REGS);
        end
    end

    // Scan from rr_q; each grant takes the next free port and blocks its idx for later requesters.
    always_comb begin
        granted    = '0;
        port_of    = '0;
        port_used  = '0;
        port_req   = '0;
        port_idx   = '0;
        any_grant  = 1'b0;
        last_grant = rr_q;
        n_grant    = 0;
        scan_r     = 0;
        collide    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_r = 32'(rr_q) + i;
            if (scan_r >= N_REQ) begin
                scan_r = scan_r - N_REQ;
            end
            collide = 1'b0;
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                if (port_used[k] && port_idx[k] == req_idx_i[scan_r]) begin
                    collide = 1'b1;
                end
            end
            if (eligible[scan_r] && n_grant < N_PORTS && !collide) begin
                granted[scan_r] = 1'b1;
                port_of[scan_r] = PORT_W'(n_grant);
                for (int unsigned k = 0; k < N_PORTS; k++) begin
                    if (k == n_grant) begin
                        port_used[k] = 1'b1;
                        port_req[k]  = RR_W'(scan_r);
                        port_idx[k]  = req_idx_i[scan_r];
                    end
                end
                n_grant    = n_grant + 1;
                any_grant  = 1'b1;
                last_grant = RR_W'(scan_r);
            end
        end
    end

    always_comb begin
        if (32'(last_grant) == N_REQ - 1) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = last_grant + RR_W'(1);
        end
    end

    always_comb begin
        rf_check_o     = '0;
        rf_set_o       = '0;
        rf_idx_o       = '0;
        rf_idx_valid_o = '0;
        rf_sd_o        = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (port_used[k] && !rst_i) begin
                rf_idx_valid_o[k] = 1'b1;
                rf_idx_o[k]       = port_idx[k];
                rf_sd_o[k]        = req_sd_i[port_req[k]];
                rf_check_o[k]     = req_check_i[port_req[k]];
                rf_set_o[k]       = !req_check_i[port_req[k]];
            end
        end
    end

    assign req_ready_o = rst_i ? '0 : granted;

    always_comb begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
            rsp_hit[r] = req_check_i[r] && rf_present_i[port_of[r]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            rsp_valid_q <= '0;
            rsp_sync_q  <= '0;
            rsp_sd_q    <= '0;
        end else begin
            if (any_grant) begin
                rr_q <= rr_nxt;
            end
            for (int unsigned r = 0; r < N_REQ; r++) begin
                if (granted[r]) begin
                    rsp_valid_q[r] <= 1'b1;
                    rsp_sync_q[r]  <= rsp_hit[r];
                    rsp_sd_q[r]    <= rsp_hit[r] ? rf_sd_i[port_of[r]] : '0;
                end else if (rsp_valid_q[r] && rsp_ready_i[r]) begin
                    rsp_valid_q[r] <= 1'b0;
                    rsp_sync_q[r]  <= 1'b0;
                    rsp_sd_q[r]    <= '0;
                end
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sync_o  = rsp_sync_q;
    assign rsp_sd_o    = rsp_sd_q;

endmodule

// File: tb/tb_fractal_sync_rf_arbiter.sv
// Bench for fractal_sync_rf_arbiter: single-cycle grant vectors from reset plus multi-cycle sequences,
// with a small behavioural RF (check on absent stores, check on present completes and clears).
module tb_fractal_sync_rf_arbiter;

    localparam int N_REQ = 4;
    localparam int N_PORTS = 2;
    localparam int N_REGS = 4;
    localparam int IDX_WIDTH = 3;
    localparam int SDW = fractal_sync_pkg::SD_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_REQ-1:0]                  req_valid = '0;
    logic [N_REQ-1:0]                  req_ready;
    logic [N_REQ-1:0]                  req_check = '0;
    logic [N_REQ-1:0][IDX_WIDTH-1:0]   req_idx = '0;
    logic [N_REQ-1:0][SDW-1:0]         req_sd = {2'b11, 2'b00, 2'b10, 2'b01};
    logic [N_REQ-1:0]                  rsp_valid;
    logic [N_REQ-1:0]                  rsp_ready = '1;
    logic [N_REQ-1:0]                  rsp_sync;
    logic [N_REQ-1:0][SDW-1:0]         rsp_sd;
    logic [N_PORTS-1:0]                rf_check;
    logic [N_PORTS-1:0]                rf_set;
    logic [N_PORTS-1:0][IDX_WIDTH-1:0] rf_idx;
    logic [N_PORTS-1:0]                rf_idx_valid;
    logic [N_PORTS-1:0][SDW-1:0]       rf_sd_out;
    logic [N_PORTS-1:0]                rf_present;
    logic [N_PORTS-1:0][SDW-1:0]       rf_sd_in;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fractal_sync_rf_arbiter #(
        .N_REQ(N_REQ), .N_PORTS(N_PORTS), .N_REGS(N_REGS), .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_check_i(req_check),
        .req_idx_i(req_idx), .req_sd_i(req_sd),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_sync_o(rsp_sync), .rsp_sd_o(rsp_sd),
        .rf_check_o(rf_check), .rf_set_o(rf_set), .rf_idx_o(rf_idx), .rf_idx_valid_o(rf_idx_valid),
        .rf_sd_o(rf_sd_out), .rf_present_i(rf_present), .rf_sd_i(rf_sd_in)
    );

    // Behavioural RF
    logic           m_present [N_REGS];
    logic [SDW-1:0] m_sd      [N_REGS];

    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            rf_present[k] = 1'b0;
            rf_sd_in[k]   = '0;
            if (int'(rf_idx[k]) < N_REGS) begin
                rf_present[k] = m_present[int'(rf_idx[k])];
                rf_sd_in[k]   = m_sd[int'(rf_idx[k])];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                m_present[i] <= 1'b0;
                m_sd[i]      <= '0;
            end
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (rf_idx_valid[k] && int'(rf_idx[k]) < N_REGS) begin
                    if (rf_set[k] || !m_present[int'(rf_idx[k])]) begin
                        m_present[int'(rf_idx[k])] <= 1'b1;
                        m_sd[int'(rf_idx[k])]      <= rf_sd_out[k];
                    end else begin
                        m_present[int'(rf_idx[k])] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] port_word(input int k);
        return 32'({rf_idx_valid[k], rf_idx[k], rf_sd_out[k], rf_check[k], rf_set[k]});
    endfunction

    function automatic logic [31:0] exp_port(input int r, input logic [N_REQ-1:0] chk,
                                             input logic [N_REQ-1:0][IDX_WIDTH-1:0] idx);
        if (r < 0) return 32'd0;
        return 32'({1'b1, idx[r], req_sd[r], chk[r], !chk[r]});
    endfunction

    function automatic logic [31:0] rsp_word(input int r);
        return 32'({rsp_valid[r], rsp_sync[r], rsp_sd[r]});
    endfunction

    // Leaves the bench at a negedge with reset released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic to_posedge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N_REQ-1:0]                vld;
        logic [N_REQ-1:0]                chk;
        logic [N_REQ-1:0][IDX_WIDTH-1:0] idx;
        int                              p0;
        int                              p1;
        int                              rr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [N_REQ-1:0] exp_rdy;

        vecs[0]  = '{4'b0001, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd1},  0, -1, 1};
        vecs[1]  = '{4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0},  0,  1, 2};
        vecs[2]  = '{4'b0101, 4'b1111, {3'd0, 3'd2, 3'd0, 3'd2},  0, -1, 1};
        vecs[3]  = '{4'b0110, 4'b1101, {3'd0, 3'd3, 3'd3, 3'd0},  1, -1, 2};
        vecs[4]  = '{4'b1001, 4'b1111, {3'd1, 3'd0, 3'd0, 3'd5},  3, -1, 0};
        vecs[5]  = '{4'b1111, 4'b1111, {3'd0, 3'd0, 3'd6, 3'd7},  2, -1, 3};
        vecs[6]  = '{4'b1100, 4'b1011, {3'd2, 3'd1, 3'd0, 3'd0},  2,  3, 0};
        vecs[7]  = '{4'b0000, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd0}, -1, -1, 0};
        vecs[8]  = '{4'b1111, 4'b1111, {3'd4, 3'd4, 3'd4, 3'd4}, -1, -1, 0};
        vecs[9]  = '{4'b1010, 4'b1111, {3'd3, 3'd0, 3'd0, 3'd0},  1,  3, 0};
        vecs[10] = '{4'b1111, 4'b1111, {3'd1, 3'd1, 3'd0, 3'd0},  0,  2, 3};

        // Reset state
        #2;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rf_vld", 32'(rf_idx_valid), 32'd0);
        do_reset();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sync_sd", 32'({rsp_sync, rsp_sd}), 32'd0);
        check("reset_rr", 32'(dut.rr_q), 32'd0);

        for (int v = 0; v < 11; v++) begin
            do_reset();
            req_valid = vecs[v].vld;
            req_check = vecs[v].chk;
            req_idx   = vecs[v].idx;
            exp_rdy = '0;
            if (vecs[v].p0 >= 0) exp_rdy[vecs[v].p0] = 1'b1;
            if (vecs[v].p1 >= 0) exp_rdy[vecs[v].p1] = 1'b1;
            #1;
            check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(exp_rdy));
            check($sformatf("v%0d_port0", v), port_word(0), exp_port(vecs[v].p0, vecs[v].chk, vecs[v].idx));
            check($sformatf("v%0d_port1", v), port_word(1), exp_port(vecs[v].p1, vecs[v].chk, vecs[v].idx));
            to_posedge();
            req_valid = '0;
            check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(exp_rdy));
            check($sformatf("v%0d_rsp_sync_sd", v), 32'({rsp_sync, rsp_sd}), 32'd0);
            check($sformatf("v%0d_rr", v), 32'(dut.rr_q), 32'(vecs[v].rr));
        end

        // Check pair: first check stores, second completes with the first one's sd
        do_reset();
        req_valid = 4'b0001; req_check = '1; req_idx = {3'd0, 3'd0, 3'd0, 3'd1};
        #1 check("pair_r0_ready", 32'(req_ready), 32'b0001);
        to_posedge();
        check("pair_r0_rsp", rsp_word(0), 32'b1000);
        @(negedge clk); req_valid = '0;
        to_posedge();
        check("pair_r0_consumed", 32'(rsp_valid), 32'd0);
        @(negedge clk); req_valid = 4'b0010; req_idx = {3'd0, 3'd0, 3'd1, 3'd0};
        #1 check("pair_r1_ready", 32'(req_ready), 32'b0010);
        to_posedge();
        check("pair_r1_rsp", rsp_word(1), 32'b1101);

        // Same-idx collision: r2 wins on the following cycle
        do_reset();
        req_valid = 4'b0101; req_check = '1; req_idx = '0;
        #1 check("coll_ready0", 32'(req_ready), 32'b0001);
        to_posedge();
        check("coll_rsp_valid0", 32'(rsp_valid), 32'b0001);
        @(negedge clk); req_valid = 4'b0100;
        #1 check("coll_ready1", 32'(req_ready), 32'b0100);
        to_posedge();
        check("coll_r2_rsp", rsp_word(2), 32'b1101);

        // Port limit with pending responses held
        do_reset();
        req_valid = 4'b1111; req_check = '1; req_idx = {3'd3, 3'd2, 3'd1, 3'd0}; rsp_ready = '0;
        #1 check("plim_ready0", 32'(req_ready), 32'b0011);
        to_posedge();
        check("plim_rr0", 32'(dut.rr_q), 32'd2);
        @(negedge clk);
        #1 check("plim_ready1", 32'(req_ready), 32'b1100);
        to_posedge();
        check("plim_rr1", 32'(dut.rr_q), 32'd0);
        check("plim_rsp_valid", 32'(rsp_valid), 32'b1111);

        // Backpressure: r0 stays blocked until its response is consumed
        do_reset();
        req_valid = 4'b0001; req_check = '1; req_idx = {3'd0, 3'd0, 3'd0, 3'd2}; rsp_ready = 4'b1110;
        #1 check("bp_ready_first", 32'(req_ready), 32'b0001);
        to_posedge();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 check($sformatf("bp_blocked%0d", c), 32'(req_ready[0]), 32'd0);
            to_posedge();
            check($sformatf("bp_pending%0d", c), rsp_word(0), 32'b1000);
        end
        @(negedge clk); rsp_ready = '1;
        #1 check("bp_handshake_cycle", 32'(req_ready[0]), 32'd0);
        to_posedge();
        check("bp_consumed", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        #1 check("bp_regrant", 32'(req_ready[0]), 32'd1);
        to_posedge();
        check("bp_second_rsp", rsp_word(0), 32'b1101);

        // Set op then check sees the set's sd
        do_reset();
        req_valid = 4'b1000; req_check = 4'b0111; req_idx = {3'd1, 3'd0, 3'd0, 3'd0};
        #1 check("set_ready", 32'(req_ready), 32'b1000);
        check("set_port0", port_word(0), 32'({1'b1, 3'd1, 2'b11, 1'b0, 1'b1}));
        to_posedge();
        check("set_r3_rsp", rsp_word(3), 32'b1000);
        @(negedge clk); req_valid = 4'b0001; req_check = '1; req_idx = {3'd0, 3'd0, 3'd0, 3'd1};
        #1 check("set_chk_ready", 32'(req_ready), 32'b0001);
        to_posedge();
        check("set_chk_rsp", rsp_word(0), 32'b1111);

        // Reset mid-traffic
        do_reset();
        req_valid = 4'b1111; req_check = '1; req_idx = {3'd3, 3'd2, 3'd1, 3'd0}; rsp_ready = '0;
        to_posedge();
        check("rst_pre_rsp", 32'(rsp_valid), 32'b0011);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_port0", port_word(0), 32'd0);
        check("rst_port1", port_word(1), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); rst = 1'b0; rsp_ready = '1;
        #1;
        check("rst_rr_after", 32'(dut.rr_q), 32'd0);
        check("rst_ready_after", 32'(req_ready), 32'b0011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
